// File: rtl/vend_panel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vend_panel_arbiter                                                       |
// | Grants one of two front panels a full purchase session on the vending    |
// | core; shapes coins, forwards the selection, counts change to release.    |
// | Option macro: VEND_ARB_ROUND_ROBIN_EN (alternate winner on ties).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vend_panel_arbiter #(
  parameter int COIN_HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_quarter,
  input  logic       a_dime,
  input  logic       a_nickel,
  input  logic       a_soda,
  input  logic       a_diet,
  input  logic       b_quarter,
  input  logic       b_dime,
  input  logic       b_nickel,
  input  logic       b_soda,
  input  logic       b_diet,
  input  logic       core_give_soda,
  input  logic       core_give_diet,
  input  logic       core_change,
  output logic       core_quarter,
  output logic       core_dime,
  output logic       core_nickel,
  output logic       core_soda,
  output logic       core_diet,
  output logic       grant_a,
  output logic       grant_b,
  output logic [6:0] credit,
  output logic       session_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GRANT     = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_SELECT    = 3'd4;
  localparam logic [2:0] S_VEND_WAIT = 3'd5;
  localparam logic [2:0] S_CHANGE    = 3'd6;
  localparam logic [2:0] S_RELEASE   = 3'd7;

  localparam int             HOLD_W    = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(COIN_HOLD - 1);
  localparam logic [6:0]     PRICE     = 7'd45;

  logic [2:0]        state_q,    state_d;
  logic              grant_a_q,  grant_a_d;
  logic              grant_b_q,  grant_b_d;
  logic              arm_q,      arm_d;
  logic [6:0]        credit_q,   credit_d;
  logic [2:0]        coin_q,     coin_d;      // {quarter, dime, nickel}
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        sel_q,      sel_d;       // {soda, diet}
  logic [2:0]        chg_cnt_q,  chg_cnt_d;
  logic              done_q,     done_d;
`ifdef VEND_ARB_ROUND_ROBIN_EN
  logic              last_b_q,   last_b_d;
`endif

  logic       w_a_req;
  logic       w_b_req;
  logic       w_pick_a;
  logic       w_pick_b;
  logic [2:0] w_g_coin;
  logic [1:0] w_g_drink;
  logic       w_one_coin;
  logic       w_one_drink;
  logic [6:0] w_coin_val;
  logic [2:0] w_chg_load;

  assign w_a_req = a_quarter | a_dime | a_nickel;
  assign w_b_req = b_quarter | b_dime | b_nickel;

  // The non-granted panel is masked off entirely.
  assign w_g_coin  = grant_a_q ? {a_quarter, a_dime, a_nickel} :
                     grant_b_q ? {b_quarter, b_dime, b_nickel} : 3'b000;
  assign w_g_drink = grant_a_q ? {a_soda, a_diet} :
                     grant_b_q ? {b_soda, b_diet} : 2'b00;

  assign w_one_coin  = (w_g_coin == 3'b100) || (w_g_coin == 3'b010) ||
                       (w_g_coin == 3'b001);
  assign w_one_drink = (w_g_drink == 2'b10) || (w_g_drink == 2'b01);

  always_comb begin
    w_coin_val = 7'd0;
    case (w_g_coin)
      3'b100:  w_coin_val = 7'd25;
      3'b010:  w_coin_val = 7'd10;
      3'b001:  w_coin_val = 7'd5;
      default: w_coin_val = 7'd0;
    endcase
  end

  // Credit only ever lands on multiples of 5 between 45 and 65 here.
  always_comb begin
    w_chg_load = 3'd0;
    case (credit_q)
      7'd50:   w_chg_load = 3'd1;
      7'd55:   w_chg_load = 3'd2;
      7'd60:   w_chg_load = 3'd3;
      7'd65:   w_chg_load = 3'd4;
      default: w_chg_load = 3'd0;
    endcase
  end

  always_comb begin
    w_pick_a = 1'b0;
    w_pick_b = 1'b0;
    if (w_a_req && w_b_req) begin
`ifdef VEND_ARB_ROUND_ROBIN_EN
      if (last_b_q) w_pick_a = 1'b1;
      else          w_pick_b = 1'b1;
`else
      w_pick_a = 1'b1;
`endif
    end else if (w_a_req) begin
      w_pick_a = 1'b1;
    end else if (w_b_req) begin
      w_pick_b = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_a_d  = grant_a_q;
    grant_b_d  = grant_b_q;
    arm_d      = arm_q;
    credit_d   = credit_q;
    coin_d     = coin_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    chg_cnt_d  = chg_cnt_q;
    done_d     = 1'b0;
`ifdef VEND_ARB_ROUND_ROBIN_EN
    last_b_d   = last_b_q;
`endif

    // Release is tracked through the whole coin phase so a panel that lets go
    // during HOLD/GAP is ready as soon as GRANT is re-entered.
    if (((state_q == S_GRANT) || (state_q == S_HOLD) || (state_q == S_GAP)) &&
        (w_g_coin == 3'b000)) begin
      arm_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_RELEASE: begin
        state_d = S_IDLE;
        if (w_pick_a || w_pick_b) begin
          grant_a_d = w_pick_a;
          grant_b_d = w_pick_b;
          arm_d     = 1'b1;
          state_d   = S_GRANT;
`ifdef VEND_ARB_ROUND_ROBIN_EN
          last_b_d  = w_pick_b;
`endif
        end
      end
      S_GRANT: begin
        if (arm_q && w_one_coin) begin
          arm_d      = 1'b0;
          credit_d   = credit_q + w_coin_val;
          coin_d     = w_g_coin;
          hold_cnt_d = HOLD_LOAD;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          coin_d  = 3'b000;
          state_d = S_GAP;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_GAP: begin
        state_d = (credit_q >= PRICE) ? S_SELECT : S_GRANT;
      end
      S_SELECT: begin
        if (w_one_drink) begin
          sel_d     = w_g_drink;
          chg_cnt_d = w_chg_load;
          state_d   = S_VEND_WAIT;
        end
      end
      S_VEND_WAIT: begin
        if (core_give_soda || core_give_diet) begin
          sel_d = 2'b00;
          if (chg_cnt_q == 3'd0) begin
            state_d   = S_RELEASE;
            done_d    = 1'b1;
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            credit_d  = 7'd0;
            arm_d     = 1'b0;
          end else begin
            state_d = S_CHANGE;
          end
        end
      end
      S_CHANGE: begin
        if (core_change) begin
          chg_cnt_d = chg_cnt_q - 3'd1;
          if (chg_cnt_q == 3'd1) begin
            state_d   = S_RELEASE;
            done_d    = 1'b1;
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            credit_d  = 7'd0;
            arm_d     = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_a_q  <= 1'b0;
      grant_b_q  <= 1'b0;
      arm_q      <= 1'b0;
      credit_q   <= 7'd0;
      coin_q     <= 3'b000;
      hold_cnt_q <= '0;
      sel_q      <= 2'b00;
      chg_cnt_q  <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_a_q  <= grant_a_d;
      grant_b_q  <= grant_b_d;
      arm_q      <= arm_d;
      credit_q   <= credit_d;
      coin_q     <= coin_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
      chg_cnt_q  <= chg_cnt_d;
      done_q     <= done_d;
    end
  end

`ifdef VEND_ARB_ROUND_ROBIN_EN
  // Resets to B so that panel A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end
`endif

  assign core_quarter = coin_q[2];
  assign core_dime    = coin_q[1];
  assign core_nickel  = coin_q[0];
  assign core_soda    = sel_q[1];
  assign core_diet    = sel_q[0];
  assign grant_a      = grant_a_q;
  assign grant_b      = grant_b_q;
  assign credit       = credit_q;
  assign session_done = done_q;

  a_grant_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(grant_a_q && grant_b_q));
  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    credit_q <= 7'd65);

endmodule
`default_nettype wire
